mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Memory/writeback pipeline stage of the core. It registers the result of the memory stage and selects the writeback source: ALU result, load data or PC+4. It sign- or zero-extends sub-word loads and drives the write port of the register file. It also flags misaligned loads and, optionally, counts retired instructions.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk_i  in  1  clock; stage register updates on posedge.
- rst_i  in  1  reset, asynchronous, active-high.
- valid_i  in  1  MEM holds a real instruction this cycle.
- stall_i  in  1  MEM is not delivering this cycle; stage loads a bubble.
- flush_i  in  1  kill the instruction in MEM; stage loads a bubble.
- rd_label_i  in  5  destination register.
- reg_write_en_i  in  1  instruction writes rd.
- wb_sel_i  in  2  writeback source: 00 ALU, 01 load, 10 PC+4, 11 reserved (handled as ALU).
- funct3_i  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- addr_lo_i  in  2  byte offset of the load address (ALU result bits 1:0).
- alu_result_i  in  32  ALU result.
- load_data_i  in  32  raw word read from data memory (word-aligned).
- pc_plus4_i  in  32  PC+4 of the instruction.
- valid_o  out  1  WB holds a real instruction.
- rd_label_o  out  5  register-file write address.
- rd_data_o  out  32  register-file write data.
- reg_write_en_o  out  1  register-file write enable.
- misalign_o  out  1  WB instruction is a misaligned load.
- instret_o  out  64  retired-instruction count (only when WB_INSTRET_EN is defined).

## Operation
- Capture condition: capture = valid_i & ~stall_i & ~flush_i. Priority order is flush, then stall, then valid.
- On capture:
  - valid_o <= 1.
  - rd_label_o <= rd_label_i.
  - rd_data_o <= formatted data (see below).
  - reg_write_en_o <= reg_write_en_i & (rd_label_i != 0) & ~misaligned.
  - misalign_o <= misaligned.
- Without capture (bubble): valid_o, reg_write_en_o and misalign_o are set to 0. rd_label_o and rd_data_o hold their previous values.
- Source select: 00 or 11 gives alu_result_i; 10 gives pc_plus4_i; 01 gives the load-formatted value.
- Load formatting:
  - Byte selected: load_data_i[8*addr_lo_i +: 8].
  - Halfword selected: load_data_i[16*addr_lo_i[1] +: 16].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
  - funct3 011, 110 or 111 with wb_sel 01 gives data 32'h0 and a normal write.
- Misaligned (only when wb_sel_i == 01):
  - LH or LHU with addr_lo_i[0] == 1.
  - LW with addr_lo_i != 0.
  - A misaligned load produces data 32'h0 and no write; valid_o is still 1.
- rd = x0: reg_write_en_o is never 1. This is a second guarantee on top of the register file's own x0 protection.

## Timing
- Latency is one cycle. Inputs sampled at posedge N appear on the outputs after posedge N.
- The register file writes on the negedge of cycle N+1. Its readers see the new value in the second half of that cycle, so decode needs no extra forwarding for the WB stage.
- Back-to-back captures are allowed every cycle; there is no internal backpressure.
- Reset, asynchronous and effective at any time including mid-instruction:
  - valid_o, reg_write_en_o and misalign_o are 0.
  - rd_label_o = 5'd0 and rd_data_o = 32'h0.
  - instret_o = 64'd0.
- After rst_i is released, the first posedge already captures.
- Simultaneous flush_i and stall_i: the stage loads a bubble, with the same result as either signal alone.

## Configuration
- WB_INSTRET_EN defined:
  - The instret_o port exists.
  - A 64-bit counter increments at every posedge where capture is 1, misaligned loads included.
  - The counter wraps from 2^64-1 to 0.
  - It is cleared by rst_i.
- WB_INSTRET_EN undefined: the port and the counter are absent; all other behaviour is identical.

## Test plan
- Reset mid-run: assert rst_i asynchronously while reg_write_en_o = 1. Required: reg_write_en_o, valid_o and rd_data_o go to 0 immediately, before the next clock edge.
- ALU writeback: capture with rd=5, wb_sel=00, alu=32'hDEADBEEF. Required after one posedge: rd_label_o=5, rd_data_o=32'hDEADBEEF, reg_write_en_o=1; the register file reads x5=32'hDEADBEEF after the negedge.
- Load extension with load_data=32'h80FF7F01. Required:
  - LB with addr_lo=3 gives 32'hFFFFFF80.
  - LBU with addr_lo=2 gives 32'h000000FF.
  - LH with addr_lo=2 gives 32'hFFFF80FF.
  - LHU with addr_lo=0 gives 32'h00007F01.
- Misaligned and x0: LW with addr_lo=1 gives misalign_o=1, reg_write_en_o=0, valid_o=1. A write to rd=0 with wb_sel=10 gives reg_write_en_o=0.
- Flush, stall and counter: send 4 valid instructions with flush_i on the 2nd and stall_i on the 3rd. Required: valid_o sequence 1,0,0,1. With WB_INSTRET_EN defined, instret_o=2; preloading the counter to 2^64-1 and capturing one instruction gives 0.

Source files
------------

// File: rtl/mem_wb_if.sv
// mem_wb_if: signal bundle between the MEM stage, the MEM/WB stage register and the
// register-file write port.
//
// master modport: MEM side. It drives the instruction fields and observes the
//                 writeback outputs.
// slave modport:  mem_wb_stage. It receives the instruction fields and drives the
//                 writeback outputs.
//
// Signals:
//   valid_i, stall_i, flush_i      MEM-side qualifiers for the instruction
//   rd_label_i, reg_write_en_i     destination register and its write intent
//   wb_sel_i, funct3_i, addr_lo_i  writeback source, load type, load byte offset
//   alu_result_i, load_data_i      ALU result and raw memory word
//   pc_plus4_i                     link value
//   valid_o, rd_label_o, rd_data_o register-file write port plus the WB valid flag
//   reg_write_en_o, misalign_o
//   instret_o                      retired-instruction count (WB_INSTRET_EN only)
//
// Optional feature macro: WB_INSTRET_EN adds instret_o.
interface mem_wb_if;
  logic        valid_i;
  logic        stall_i;
  logic        flush_i;
  logic [4:0]  rd_label_i;
  logic        reg_write_en_i;
  logic [1:0]  wb_sel_i;
  logic [2:0]  funct3_i;
  logic [1:0]  addr_lo_i;
  logic [31:0] alu_result_i;
  logic [31:0] load_data_i;
  logic [31:0] pc_plus4_i;

  logic        valid_o;
  logic [4:0]  rd_label_o;
  logic [31:0] rd_data_o;
  logic        reg_write_en_o;
  logic        misalign_o;
`ifdef WB_INSTRET_EN
  logic [63:0] instret_o;
`endif

  modport master (
    output valid_i, stall_i, flush_i, rd_label_i, reg_write_en_i, wb_sel_i, funct3_i,
           addr_lo_i, alu_result_i, load_data_i, pc_plus4_i,
`ifdef WB_INSTRET_EN
    input  instret_o,
`endif
    input  valid_o, rd_label_o, rd_data_o, reg_write_en_o, misalign_o
  );

  modport slave (
    input  valid_i, stall_i, flush_i, rd_label_i, reg_write_en_i, wb_sel_i, funct3_i,
           addr_lo_i, alu_result_i, load_data_i, pc_plus4_i,
`ifdef WB_INSTRET_EN
    output instret_o,
`endif
    output valid_o, rd_label_o, rd_data_o, reg_write_en_o, misalign_o
  );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory/writeback pipeline register.
//
// Registers the MEM-stage result and selects the writeback value: ALU result,
// formatted load data or PC+4. Sub-word loads are sign- or zero-extended.
// Misaligned halfword/word loads are flagged: they still occupy the WB slot
// (valid_o = 1) but write nothing and carry zero data. Writes to x0 are
// suppressed here as well as in the register file.
//
// Ports:
//   clk_i  stage clock; the stage register updates on the rising edge
//   rst_i  asynchronous, active-high reset
//   bus    mem_wb_if.slave; MEM-stage inputs and register-file write port outputs
//
// Optional feature macro: WB_INSTRET_EN adds a 64-bit retired-instruction counter
// on bus.instret_o. It counts every capture, misaligned loads included.
module mem_wb_stage #(
  parameter int unsigned XLEN = 32  // only 32 is supported
) (
  input  logic     clk_i,
  input  logic     rst_i,
  mem_wb_if.slave  bus
);

  localparam logic [1:0] WbAlu  = 2'b00;
  localparam logic [1:0] WbLoad = 2'b01;
  localparam logic [1:0] WbPc4  = 2'b10;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;

  // Stage state.
  logic            valid_q, valid_d;
  logic [4:0]      rd_label_q, rd_label_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic            we_q, we_d;
  logic            misalign_q, misalign_d;

  // Decode.
  logic            capture;
  logic            is_load;
  logic            misaligned;
  logic [7:0]      load_byte;
  logic [15:0]     load_half;
  logic [XLEN-1:0] load_fmt;
  logic [XLEN-1:0] wb_data;

  // Flush wins over stall, stall wins over valid; any of them yields a bubble.
  assign capture = bus.valid_i & ~bus.stall_i & ~bus.flush_i;
  assign is_load = (bus.wb_sel_i == WbLoad);

  // Byte and halfword lanes out of the word-aligned memory read.
  always_comb begin
    load_byte = bus.load_data_i[7:0];
    unique case (bus.addr_lo_i)
      2'd0: load_byte = bus.load_data_i[7:0];
      2'd1: load_byte = bus.load_data_i[15:8];
      2'd2: load_byte = bus.load_data_i[23:16];
      2'd3: load_byte = bus.load_data_i[31:24];
      default: load_byte = bus.load_data_i[7:0];
    endcase
  end

  assign load_half = bus.addr_lo_i[1] ? bus.load_data_i[31:16] : bus.load_data_i[15:0];

  // Reserved load encodings (011, 110, 111) produce zero but still write.
  always_comb begin
    load_fmt = '0;
    case (bus.funct3_i)
      F3Lb:    load_fmt = {{(XLEN-8){load_byte[7]}}, load_byte};
      F3Lh:    load_fmt = {{(XLEN-16){load_half[15]}}, load_half};
      F3Lw:    load_fmt = bus.load_data_i;
      F3Lbu:   load_fmt = {{(XLEN-8){1'b0}}, load_byte};
      F3Lhu:   load_fmt = {{(XLEN-16){1'b0}}, load_half};
      default: load_fmt = '0;
    endcase
  end

  // Only load results can be misaligned; byte loads never are.
  always_comb begin
    misaligned = 1'b0;
    if (is_load) begin
      case (bus.funct3_i)
        F3Lh, F3Lhu: misaligned = bus.addr_lo_i[0];
        F3Lw:        misaligned = (bus.addr_lo_i != 2'b00);
        default:     misaligned = 1'b0;
      endcase
    end
  end

  // Writeback source; the reserved select 11 behaves as ALU.
  always_comb begin
    wb_data = bus.alu_result_i;
    case (bus.wb_sel_i)
      WbAlu:   wb_data = bus.alu_result_i;
      WbLoad:  wb_data = misaligned ? '0 : load_fmt;
      WbPc4:   wb_data = bus.pc_plus4_i;
      default: wb_data = bus.alu_result_i;
    endcase
  end

  // Next state. A bubble clears the qualifiers but keeps the last label/data so
  // the write-port address and data lines do not toggle needlessly.
  always_comb begin
    valid_d    = 1'b0;
    rd_label_d = rd_label_q;
    rd_data_d  = rd_data_q;
    we_d       = 1'b0;
    misalign_d = 1'b0;
    if (capture) begin
      valid_d    = 1'b1;
      rd_label_d = bus.rd_label_i;
      rd_data_d  = wb_data;
      we_d       = bus.reg_write_en_i & (bus.rd_label_i != 5'd0) & ~misaligned;
      misalign_d = misaligned;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      rd_label_q <= 5'd0;
      rd_data_q  <= '0;
      we_q       <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      rd_label_q <= rd_label_d;
      rd_data_q  <= rd_data_d;
      we_q       <= we_d;
      misalign_q <= misalign_d;
    end
  end

  assign bus.valid_o        = valid_q;
  assign bus.rd_label_o     = rd_label_q;
  assign bus.rd_data_o      = rd_data_q;
  assign bus.reg_write_en_o = we_q;
  assign bus.misalign_o     = misalign_q;

`ifdef WB_INSTRET_EN
  // Free-running 64-bit count of captures; wraps naturally at 2^64.
  logic [63:0] instret_q, instret_d;

  always_comb begin
    instret_d = instret_q;
    if (capture) begin
      instret_d = instret_q + 64'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instret_q <= 64'd0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign bus.instret_o = instret_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a small register-file model that writes
// on the falling edge, as the real register file does.
module tb_mem_wb_stage;
  logic clk_i = 1'b0;
  logic rst_i;

  mem_wb_if bus ();

  mem_wb_stage #(.XLEN(32)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  logic [31:0] rf [32];
  always @(negedge clk_i) begin
    if (bus.reg_write_en_o) rf[bus.rd_label_o] <= bus.rd_data_o;
  end

  int checks = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present one valid, non-stalled instruction.
  task automatic inst(input logic [4:0] rd, input logic we, input logic [1:0] sel,
                      input logic [2:0] f3, input logic [1:0] lo);
    bus.valid_i        = 1'b1;
    bus.stall_i        = 1'b0;
    bus.flush_i        = 1'b0;
    bus.rd_label_i     = rd;
    bus.reg_write_en_i = we;
    bus.wb_sel_i       = sel;
    bus.funct3_i       = f3;
    bus.addr_lo_i      = lo;
  endtask

  task automatic load_chk(input string tag, input logic [2:0] f3, input logic [1:0] lo,
                          input logic [31:0] exp_data, input logic exp_we,
                          input logic exp_mis);
    inst(5'd7, 1'b1, 2'b01, f3, lo);
    tick();
    chk({tag, "_data"}, {32'h0, bus.rd_data_o}, {32'h0, exp_data});
    chk({tag, "_we"}, {63'h0, bus.reg_write_en_o}, {63'h0, exp_we});
    chk({tag, "_mis"}, {63'h0, bus.misalign_o}, {63'h0, exp_mis});
  endtask

  initial begin
    rst_i = 1'b1;
    inst(5'd0, 1'b0, 2'b00, 3'b000, 2'b00);
    bus.valid_i      = 1'b0;
    bus.alu_result_i = 32'h0;
    bus.load_data_i  = 32'h0;
    bus.pc_plus4_i   = 32'h0;
    #3;
    chk("rst_valid", {63'h0, bus.valid_o}, 64'h0);
    chk("rst_we", {63'h0, bus.reg_write_en_o}, 64'h0);
    chk("rst_mis", {63'h0, bus.misalign_o}, 64'h0);
    chk("rst_label", {59'h0, bus.rd_label_o}, 64'h0);
    chk("rst_data", {32'h0, bus.rd_data_o}, 64'h0);
`ifdef WB_INSTRET_EN
    chk("rst_instret", bus.instret_o, 64'h0);
`endif
    @(negedge clk_i);
    rst_i = 1'b0;

    // ALU writeback to x5.
    inst(5'd5, 1'b1, 2'b00, 3'b000, 2'b00);
    bus.alu_result_i = 32'hDEADBEEF;
    tick();
    chk("alu_valid", {63'h0, bus.valid_o}, 64'h1);
    chk("alu_label", {59'h0, bus.rd_label_o}, 64'd5);
    chk("alu_data", {32'h0, bus.rd_data_o}, 64'hDEADBEEF);
    chk("alu_we", {63'h0, bus.reg_write_en_o}, 64'h1);
    @(negedge clk_i);
    #1;
    chk("rf_x5", {32'h0, rf[5]}, 64'hDEADBEEF);

    // Asynchronous reset while a write is pending, away from any rising edge.
    rst_i = 1'b1;
    #1;
    chk("mid_rst_we", {63'h0, bus.reg_write_en_o}, 64'h0);
    chk("mid_rst_valid", {63'h0, bus.valid_o}, 64'h0);
    chk("mid_rst_data", {32'h0, bus.rd_data_o}, 64'h0);
    rst_i = 1'b0;
    // First edge after release captures the still-presented ALU instruction.
    tick();
    chk("post_rst_valid", {63'h0, bus.valid_o}, 64'h1);
    chk("post_rst_data", {32'h0, bus.rd_data_o}, 64'hDEADBEEF);

    // Load formatting on 32'h80FF7F01.
    bus.load_data_i = 32'h80FF7F01;
    load_chk("lb3", 3'b000, 2'd3, 32'hFFFFFF80, 1'b1, 1'b0);
    load_chk("lbu2", 3'b100, 2'd2, 32'h000000FF, 1'b1, 1'b0);
    load_chk("lh2", 3'b001, 2'd2, 32'hFFFF80FF, 1'b1, 1'b0);
    load_chk("lhu0", 3'b101, 2'd0, 32'h00007F01, 1'b1, 1'b0);
    load_chk("lb1", 3'b000, 2'd1, 32'h0000007F, 1'b1, 1'b0);
    load_chk("lw0", 3'b010, 2'd0, 32'h80FF7F01, 1'b1, 1'b0);
    load_chk("rsv011", 3'b011, 2'd0, 32'h00000000, 1'b1, 1'b0);
    load_chk("lh1_mis", 3'b001, 2'd1, 32'h00000000, 1'b0, 1'b1);
    load_chk("lw1_mis", 3'b010, 2'd1, 32'h00000000, 1'b0, 1'b1);
    chk("lw1_mis_valid", {63'h0, bus.valid_o}, 64'h1);

    // Flush together with stall: bubble, qualifiers cleared, label held.
    inst(5'd12, 1'b1, 2'b00, 3'b000, 2'b00);
    bus.stall_i = 1'b1;
    bus.flush_i = 1'b1;
    tick();
    chk("fs_valid", {63'h0, bus.valid_o}, 64'h0);
    chk("fs_mis", {63'h0, bus.misalign_o}, 64'h0);
    chk("fs_label", {59'h0, bus.rd_label_o}, 64'd7);

    // Link write to x0 is never enabled.
    inst(5'd0, 1'b1, 2'b10, 3'b000, 2'b00);
    bus.pc_plus4_i = 32'h00000104;
    tick();
    chk("x0_we", {63'h0, bus.reg_write_en_o}, 64'h0);
    chk("x0_data", {32'h0, bus.rd_data_o}, 64'h104);
    chk("x0_valid", {63'h0, bus.valid_o}, 64'h1);

    // Reserved select 11 behaves as ALU.
    inst(5'd9, 1'b1, 2'b11, 3'b000, 2'b00);
    bus.alu_result_i = 32'h12345678;
    tick();
    chk("sel11_data", {32'h0, bus.rd_data_o}, 64'h12345678);
    chk("sel11_we", {63'h0, bus.reg_write_en_o}, 64'h1);

    // Four instructions, flush on the 2nd, stall on the 3rd, from a fresh reset.
    rst_i = 1'b1;
    #1;
    rst_i = 1'b0;
    bus.alu_result_i = 32'h0000AAAA;
    inst(5'd3, 1'b1, 2'b00, 3'b000, 2'b00);
    tick();
    chk("seq1_valid", {63'h0, bus.valid_o}, 64'h1);
    inst(5'd10, 1'b1, 2'b00, 3'b000, 2'b00);
    bus.flush_i = 1'b1;
    bus.alu_result_i = 32'h0000BBBB;
    tick();
    chk("seq2_valid", {63'h0, bus.valid_o}, 64'h0);
    chk("seq2_label", {59'h0, bus.rd_label_o}, 64'd3);
    chk("seq2_data", {32'h0, bus.rd_data_o}, 64'hAAAA);
    chk("seq2_we", {63'h0, bus.reg_write_en_o}, 64'h0);
    inst(5'd11, 1'b1, 2'b00, 3'b000, 2'b00);
    bus.stall_i = 1'b1;
    tick();
    chk("seq3_valid", {63'h0, bus.valid_o}, 64'h0);
    inst(5'd4, 1'b1, 2'b00, 3'b000, 2'b00);
    bus.alu_result_i = 32'h0000CCCC;
    tick();
    chk("seq4_valid", {63'h0, bus.valid_o}, 64'h1);
    chk("seq4_data", {32'h0, bus.rd_data_o}, 64'hCCCC);
`ifdef WB_INSTRET_EN
    chk("instret_2", bus.instret_o, 64'd2);
    // Preload to all-ones and retire one more: the counter wraps to zero.
    @(negedge clk_i);
    dut.instret_q = '1;
    tick();
    chk("instret_wrap", bus.instret_o, 64'd0);
`endif
    bus.valid_i = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
